// File: rtl/regfile_ctrl.sv
`default_nettype none
// ============================================================================
// Module : regfile_ctrl
// Brief  : Command sequencer that drives the write/read ports of an 8x32
//          register file (LOAD / ADD / READ / CLEAR).
// Rev    : 1.0
// ============================================================================
module regfile_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wAddr,
  output logic [DATA_W-1:0] rf_wData,
  output logic [ADDR_W-1:0] rf_rAddr,
  input  logic [DATA_W-1:0] rf_rData,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              busy
);

  localparam logic [1:0]        OP_LOAD  = 2'b00;
  localparam logic [1:0]        OP_ADD   = 2'b01;
  localparam logic [1:0]        OP_READ  = 2'b10;
  localparam logic [1:0]        OP_CLEAR = 2'b11;
  localparam logic [ADDR_W-1:0] LAST_REG = {ADDR_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD1  = 3'd1,
    RD2  = 3'd2,
    WR   = 3'd3,
    CLR  = 3'd4,
    RESP = 3'd5
  } state_t;

  state_t              state;
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   rd_q;
  logic [ADDR_W-1:0]   rs1_q;
  logic [ADDR_W-1:0]   rs2_q;
  logic [ADDR_W-1:0]   cnt;
  logic [DATA_W-1:0]   imm_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   s_q;
  logic                wr_active;

  assign cmd_ready = (state == IDLE) && !reset;
  assign busy      = (state != IDLE);
  assign res_valid = (state == RESP);

  // Gating with reset keeps an aborted CLEAR/WR from landing its final write.
  assign wr_active = ((state == WR) || (state == CLR)) && !reset;
  assign rf_we     = wr_active;

  always_comb begin
    rf_wAddr = '0;
    rf_wData = '0;
    if (wr_active) begin
      if (state == CLR) begin
        rf_wAddr = cnt;
      end else begin
        rf_wAddr = rd_q;
        rf_wData = (op_q == OP_LOAD) ? imm_q : s_q;
      end
    end
  end

  always_comb begin
    rf_rAddr = '0;
    case (state)
      RD1:     rf_rAddr = rs1_q;
      RD2:     rf_rAddr = rs2_q;
      default: rf_rAddr = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      res_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            rd_q  <= cmd_rd;
            rs1_q <= cmd_rs1;
            rs2_q <= cmd_rs2;
            imm_q <= cmd_imm;
            case (cmd_op)
              OP_LOAD:  state <= WR;
              OP_ADD:   state <= RD1;
              OP_READ:  state <= RD1;
              OP_CLEAR: begin
                state <= CLR;
                cnt   <= '0;
              end
              default:  state <= IDLE;
            endcase
          end
        end
        RD1: begin
          if (op_q == OP_ADD) begin
            a_q   <= rf_rData;
            state <= RD2;
          end else begin
            res_data <= rf_rData;
            state    <= RESP;
          end
        end
        RD2: begin
          s_q   <= a_q + rf_rData;
          state <= WR;
        end
        WR: state <= IDLE;
        CLR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_REG) state <= IDLE;
        end
        RESP: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
